// File: rtl/bus_arbiter_pkg.sv
// Shared parameters for the L1/L2 bus arbiter: message codes, FSM encodings, response test.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bus_arbiter_pkg;

    localparam int MSG_W = 4;
    typedef logic [MSG_W-1:0] msg_t;

    // Bus message codes
    localparam msg_t NO_REQ     = 4'h0;
    localparam msg_t R_REQ      = 4'h1;
    localparam msg_t RX_REQ     = 4'h2;
    localparam msg_t WB_REQ     = 4'h3;
    localparam msg_t MEM_RESP   = 4'h8;
    localparam msg_t MEM_RESP_S = 4'h9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // True when the shared bus carries a memory response that completes the owner's transaction
    function automatic logic is_mem_resp(input msg_t m);
        return (m == MEM_RESP) || (m == MEM_RESP_S);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Round-robin selector: first set request bit searching upward from last_idx+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; vld low when no request bit is set.
//
// Ports: req (request vector), last_idx (previous winner), vld (any request), idx (winner).
module rr_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic          vld,
    output logic [IW-1:0] idx
);

    // Walk the offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin : sel
        int j;
        vld = 1'b0;
        idx = last_idx;
        j   = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(last_idx) + k) % N;
            if (req[j]) begin
                vld = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting the shared L2 bus to one L1 interface at a time.
// Latency: grant 1 cycle after request; 1-cycle RELEASE gap between owners.
// Backpressure: a port waits (req_ready low) until granted; served ports are masked until they go idle.
//
// Ports: clock, reset (async active-low), req_msg (packed per-port messages), bus_msg_in (shared
// response), bus_master / req_ready (one-hot grant), active_port (owner index, holds last owner),
// bus_busy, timeout_err (watchdog pulse).
// Optional feature: define ARB_TIMEOUT_EN to enable the grant watchdog (TIMEOUT_CYCLES).
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int MSG_BITS       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_PORTS*MSG_BITS-1:0]    req_msg,
    input  logic [MSG_BITS-1:0]              bus_msg_in,
    output logic [NUM_PORTS-1:0]             bus_master,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [$clog2(NUM_PORTS)-1:0]     active_port,
    output logic                             bus_busy,
    output logic                             timeout_err
);

    localparam int IW = $clog2(NUM_PORTS);

    arb_state_t          state, state_nxt;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       last_owner;
    logic [NUM_PORTS-1:0] served;
    logic [NUM_PORTS-1:0] req_active;
    logic [NUM_PORTS-1:0] req_pending;
    logic                sel_vld;
    logic [IW-1:0]       sel_idx;
    logic                resp_hit;
    logic                owner_idle;
    logic                wd_expire;
    logic                set_served;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_active[i] = (msg_t'(req_msg[i*MSG_BITS +: MSG_BITS]) != NO_REQ);
        end
    end

    // Served ports stay masked until they show NO_REQ, so a stale request cannot win again.
    assign req_pending = req_active & ~served;
    assign resp_hit    = is_mem_resp(msg_t'(bus_msg_in));
    assign owner_idle  = ~req_active[owner];
    assign set_served  = (state == GRANT) && (resp_hit || wd_expire);

    rr_select #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_rr_select (
        .req      (req_pending),
        .last_idx (last_owner),
        .vld      (sel_vld),
        .idx      (sel_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (state == GRANT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    // Count is 0 in the first grant cycle, so expiry lands on grant cycle TIMEOUT_CYCLES.
    assign wd_expire = (state == GRANT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = GRANT;
            GRANT:   if (resp_hit || wd_expire || owner_idle) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner bookkeeping and served mask
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner      <= '0;
            last_owner <= IW'(NUM_PORTS - 1);
            served     <= '0;
        end else begin
            if ((state == IDLE) && sel_vld) begin
                owner      <= sel_idx;
                last_owner <= sel_idx;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (set_served && (owner == IW'(i))) served[i] <= 1'b1;
                if (!req_active[i])                  served[i] <= 1'b0;
            end
        end
    end

    // Outputs decode from the state register, so an async reset drops the grant at once.
    always_comb begin
        bus_master = '0;
        bus_busy   = 1'b0;
        if (state == GRANT) begin
            bus_master[owner] = 1'b1;
            bus_busy          = 1'b1;
        end
    end

    assign req_ready   = bus_master;
    assign active_port = owner;
    assign timeout_err = wd_expire;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant, release, round-robin, stale masking, async reset, watchdog.
// Latency: n/a.
// Backpressure: n/a.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic [15:0] req_msg;
    logic [3:0]  bus_msg_in;
    logic [3:0]  bus_master;
    logic [3:0]  req_ready;
    logic [1:0]  active_port;
    logic        bus_busy;
    logic        timeout_err;

    int vectors;
    int miscompares;

    bus_arbiter #(
        .NUM_PORTS      (4),
        .MSG_BITS       (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_msg     (req_msg),
        .bus_msg_in  (bus_msg_in),
        .bus_master  (bus_master),
        .req_ready   (req_ready),
        .active_port (active_port),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_port(input int idx, input msg_t m);
        req_msg[idx*4 +: 4] = m;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        req_msg     = '0;
        bus_msg_in  = NO_REQ;
        #1;
        chk("rst_master", 32'(bus_master), 32'h0);
        chk("rst_ready",  32'(req_ready),  32'h0);
        chk("rst_busy",   32'(bus_busy),   32'h0);
        chk("rst_tmo",    32'(timeout_err), 32'h0);
        chk("rst_active", 32'(active_port), 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Single write-back request on port 2, then memory response
        set_port(2, WB_REQ);
        tick();
        chk("p2_master", 32'(bus_master), 32'h4);
        chk("p2_ready",  32'(req_ready),  32'h4);
        chk("p2_active", 32'(active_port), 32'h2);
        chk("p2_busy",   32'(bus_busy),   32'h1);
        bus_msg_in = MEM_RESP;
        tick();
        chk("p2_rel_master", 32'(bus_master), 32'h0);
        chk("p2_rel_busy",   32'(bus_busy),   32'h0);
        bus_msg_in = NO_REQ;
        set_port(2, NO_REQ);
        tick();
        chk("p2_idle_master", 32'(bus_master), 32'h0);

        // Port 1 keeps R_REQ after MEM_RESP_S: must not be re-granted until it goes idle
        set_port(1, R_REQ);
        tick();
        chk("p1_master", 32'(bus_master), 32'h2);
        chk("p1_active", 32'(active_port), 32'h1);
        bus_msg_in = MEM_RESP_S;
        tick();
        bus_msg_in = NO_REQ;
        chk("p1_rel_master", 32'(bus_master), 32'h0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("stale_hold", 32'(bus_master), 32'h0);
        end
        set_port(1, NO_REQ);
        tick();
        chk("stale_clear", 32'(bus_master), 32'h0);
        set_port(1, R_REQ);
        tick();
        chk("p1_regrant", 32'(bus_master), 32'h2);

        // A new request from a non-owner does not disturb the grant
        set_port(3, WB_REQ);
        tick();
        chk("nonowner_master", 32'(bus_master), 32'h2);
        chk("nonowner_active", 32'(active_port), 32'h1);
        set_port(3, NO_REQ);

        // Owner withdraws without a response, then requests again
        set_port(1, NO_REQ);
        tick();
        chk("drop_rel", 32'(bus_master), 32'h0);
        tick();
        chk("drop_idle", 32'(bus_master), 32'h0);
        set_port(1, R_REQ);
        tick();
        chk("drop_regrant", 32'(bus_master), 32'h2);

        // Async reset in GRANT drops the grant before any clock edge
        reset = 1'b0;
        #1;
        chk("arst_master", 32'(bus_master), 32'h0);
        chk("arst_busy",   32'(bus_busy),   32'h0);
        chk("arst_active", 32'(active_port), 32'h0);
        set_port(1, NO_REQ);
        set_port(0, R_REQ);
        set_port(3, WB_REQ);
        tick();
        tick();
        reset = 1'b1;

        // Ports 0 and 3 together with last_owner=3: port 0 first, port 3 two cycles after response
        tick();
        chk("rr_p0_master", 32'(bus_master), 32'h1);
        chk("rr_p0_active", 32'(active_port), 32'h0);
        bus_msg_in = MEM_RESP;
        tick();
        bus_msg_in = NO_REQ;
        chk("rr_rel", 32'(bus_master), 32'h0);
        tick();
        chk("rr_idle", 32'(bus_master), 32'h0);
        tick();
        chk("rr_p3_master", 32'(bus_master), 32'h8);
        chk("rr_p3_active", 32'(active_port), 32'h3);

        // Port 3 never sees a response; port 2 waits behind it
        set_port(2, R_REQ);
`ifdef ARB_TIMEOUT_EN
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk("wd_pulse",  32'(timeout_err), (k == 8) ? 32'h1 : 32'h0);
            chk("wd_master", 32'(bus_master),  32'h8);
        end
        tick();
        chk("wd_rel_master", 32'(bus_master), 32'h0);
        chk("wd_rel_tmo",    32'(timeout_err), 32'h0);
        tick();
        tick();
        chk("wd_next_master", 32'(bus_master), 32'h4);
        chk("wd_next_active", 32'(active_port), 32'h2);
`else
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("hold_master", 32'(bus_master),  32'h8);
            chk("hold_tmo",    32'(timeout_err), 32'h0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of L1 bus interfaces sharing the bus (2..8).
REQ-002 Parameter MSG_BITS, default 4: message width; codes NO_REQ, MEM_RESP, MEM_RESP_S come from the shared params include.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: watchdog limit; used only with ARB_TIMEOUT_EN.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_msg  input  NUM_PORTS*MSG_BITS  packed bus_msg_out of each interface; port i occupies bits [i*MSG_BITS +: MSG_BITS].
REQ-007 bus_msg_in  input  MSG_BITS  response message on the shared bus from L2/memory.
REQ-008 bus_master  output  NUM_PORTS  one-hot ownership grant, one bit per interface.
REQ-009 req_ready  output  NUM_PORTS  request-accepted strobe per interface, level-held while owned.
REQ-010 active_port  output  log2(NUM_PORTS)  index of the current owner; holds the last owner when idle.
REQ-011 bus_busy  output  1  high while any port owns the bus.
REQ-012 timeout_err  output  1  one-cycle pulse on watchdog expiry; tied 0 without ARB_TIMEOUT_EN.

Function
REQ-013 Port i SHALL be requesting when its req_msg slice is not NO_REQ and its served bit is clear.
REQ-014 FSM states SHALL be IDLE, GRANT and RELEASE.
REQ-015 In IDLE with at least one requesting port, the arbiter SHALL select the first requesting port searching upward from (last_owner+1) mod NUM_PORTS, and SHALL enter GRANT on the next edge.
REQ-016 In GRANT, bus_master[owner] and req_ready[owner] SHALL be high; all other bits SHALL be 0. Latency from request to grant is 1 cycle.
REQ-017 GRANT SHALL go to RELEASE on the edge at which bus_msg_in is MEM_RESP or MEM_RESP_S, and SHALL set the owner's served bit.
REQ-018 If the owner's req_msg returns to NO_REQ while in GRANT with no response, the arbiter SHALL go to RELEASE without setting the served bit.
REQ-019 In RELEASE, bus_master and req_ready SHALL be all 0 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-020 A served bit SHALL clear on the first edge at which that port's req_msg is NO_REQ, which blocks re-grant of a stale request.
REQ-021 Requests arriving in the same cycle SHALL be resolved only by the round-robin order; a request change by a non-owner SHALL NOT affect the current grant.
REQ-022 bus_master SHALL never have more than one bit set.
REQ-023 last_owner SHALL update when GRANT is entered; the selection index SHALL wrap from NUM_PORTS-1 to 0.

Reset
REQ-024 While reset is low: state=IDLE, bus_master=0, req_ready=0, bus_busy=0, timeout_err=0, active_port=0, last_owner=NUM_PORTS-1, all served bits clear, watchdog=0.
REQ-025 Reset asserted in GRANT SHALL drop the grant immediately, without waiting for a clock edge.

Configuration
REQ-026 With ARB_TIMEOUT_EN defined, a counter SHALL increment each cycle in GRANT. On reaching TIMEOUT_CYCLES, the arbiter SHALL pulse timeout_err, set the owner's served bit and go to RELEASE.
REQ-027 Without ARB_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be constant 0, and GRANT SHALL be held indefinitely.

Structure
REQ-028 FSM state encodings and the response-code test SHALL reside in the shared params package/include, alongside the message codes.
REQ-029 The round-robin selector SHALL be a sub-module rr_select (inputs: request vector and last index; outputs: valid and index).

Verification
REQ-030 Reset low, then port 2 WB_REQ → bus_master=4'b0100 and req_ready[2]=1 one cycle later; MEM_RESP → bus_master=0 for 1 cycle, then IDLE.
REQ-031 Ports 0 and 3 request in the same cycle with last_owner=3 → port 0 granted; after MEM_RESP, port 3 is granted 2 cycles later.
REQ-032 Port 1 holds R_REQ after MEM_RESP_S and ports 0, 2 and 3 are idle → no re-grant until port 1 sends NO_REQ then R_REQ again.
REQ-033 Owner drops to NO_REQ without a response → RELEASE and no served bit set; its next request is granted normally.
REQ-034 ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no response → timeout_err pulses on grant cycle 8, then the next requester is granted.
REQ-035 Reset pulsed low in GRANT → bus_master=0 asynchronously; after release, arbitration restarts from port 0.
